// File: rtl/upower_pkg.sv
// upower_pkg: shared defaults and types for the uPower fetch slice.
//   ADDR_W_DEF / INSN_W_DEF : default address and instruction widths
//   RESET_PC_DEF            : default PC loaded on reset
//   fetch_state_e           : fetch FSM states (IDLE, FETCH, DRAIN)
package upower_pkg;

    localparam int unsigned ADDR_W_DEF   = 32;
    localparam int unsigned INSN_W_DEF   = 32;
    localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FETCH,
        ST_DRAIN
    } fetch_state_e;

endpackage

// File: rtl/upower_sync_fifo.sv
// upower_sync_fifo: synchronous FIFO with flush and occupancy count.
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   push_i/data_i : write an entry (caller guarantees space)
//   pop_i         : remove the head entry (ignored when empty)
//   flush_i       : discard all entries, overrides push/pop
//   data_o        : head entry (meaningful only when !empty_o)
//   empty_o       : no entries held
//   count_o       : number of entries held
module upower_sync_fifo #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         data_i,
    input  logic                     pop_i,
    input  logic                     flush_i,
    output logic [WIDTH-1:0]         data_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_q, rd_q;
    logic [AW:0]      cnt_q;
    logic             pop_ok;

    assign pop_ok  = pop_i && (cnt_q != '0);
    assign empty_o = (cnt_q == '0);
    assign count_o = cnt_q;
    assign data_o  = mem_q[rd_q];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else if (flush_i) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (push_i) wr_q <= wr_q + AW'(1);
            if (pop_ok) rd_q <= rd_q + AW'(1);
            cnt_q <= cnt_q + (AW+1)'(push_i) - (AW+1)'(pop_ok);
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_i && !flush_i) mem_q[wr_q] <= data_i;
    end

endmodule

// File: rtl/upower_fetch_unit.sv
// upower_fetch_unit: instruction fetch stage for the uPower core.
//   clock, reset_n                  : clock, asynchronous active-low reset
//   redirect_valid, redirect_pc     : branch redirect, flushes wrong-path work
//   imem_req_valid/ready/addr       : word fetch request channel
//   imem_resp_valid/data            : in-order fetch responses
//   dec_valid/ready, dec_instr/pc   : {instruction, pc} handed to decode
module upower_fetch_unit
    import upower_pkg::*;
#(
    parameter int unsigned        ADDR_W     = ADDR_W_DEF,
    parameter int unsigned        INSN_W     = INSN_W_DEF,
    parameter int unsigned        FIFO_DEPTH = 4,
    parameter logic [ADDR_W-1:0]  RESET_PC   = '0
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              imem_req_valid,
    input  logic              imem_req_ready,
    output logic [ADDR_W-1:0] imem_req_addr,
    input  logic              imem_resp_valid,
    input  logic [INSN_W-1:0] imem_resp_data,
    output logic              dec_valid,
    input  logic              dec_ready,
    output logic [INSN_W-1:0] dec_instr,
    output logic [ADDR_W-1:0] dec_pc
);

    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned ENT_W = INSN_W + ADDR_W;

    fetch_state_e      state_q, state_d;
    logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
    logic [ADDR_W-1:0] resp_pc_q, resp_pc_d;
    logic [CNT_W-1:0]  outst_q, outst_d;
    logic [CNT_W-1:0]  discard_q, discard_d;

    logic [CNT_W-1:0]  fifo_count;
    logic              fifo_empty;
    logic [ENT_W-1:0]  fifo_head;
    logic              resp_take, req_fire, fifo_push, fifo_pop;
    logic [CNT_W-1:0]  outst_after_resp;

    // A response with nothing outstanding is spurious and ignored.
    assign resp_take        = imem_resp_valid && (outst_q != '0);
    assign outst_after_resp = outst_q - CNT_W'(resp_take);

    // Every issued request owns a FIFO slot, so responses never need backpressure.
    assign imem_req_valid = (state_q != ST_IDLE) && !redirect_valid &&
                            ((outst_q + fifo_count) < CNT_W'(FIFO_DEPTH));
    assign imem_req_addr  = fetch_pc_q;
    assign req_fire       = imem_req_valid && imem_req_ready;

    assign fifo_push = resp_take && !redirect_valid && (discard_q == '0);
    assign fifo_pop  = !fifo_empty && dec_ready && !redirect_valid;

    assign dec_valid = !fifo_empty;
    assign dec_instr = fifo_empty ? '0 : fifo_head[ENT_W-1:ADDR_W];
    assign dec_pc    = fifo_empty ? '0 : fifo_head[ADDR_W-1:0];

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        resp_pc_d  = resp_pc_q;
        discard_d  = discard_q;
        outst_d    = outst_after_resp + CNT_W'(req_fire);

        if (redirect_valid) begin
            fetch_pc_d = redirect_pc;
            resp_pc_d  = redirect_pc;
            // Everything still in flight belongs to the wrong path.
            discard_d  = outst_after_resp;
        end else begin
            if (req_fire) fetch_pc_d = fetch_pc_q + ADDR_W'(1);
            if (resp_take) begin
                if (discard_q != '0) discard_d = discard_q - CNT_W'(1);
                else                 resp_pc_d = resp_pc_q + ADDR_W'(1);
            end
        end

        case (state_q)
            ST_IDLE:  state_d = ST_FETCH;
            ST_FETCH: begin
                if (redirect_valid && (outst_after_resp != '0)) state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (redirect_valid)
                    state_d = (outst_after_resp != '0) ? ST_DRAIN : ST_FETCH;
                else if (discard_d == '0)
                    state_d = ST_FETCH;
            end
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            fetch_pc_q <= RESET_PC;
            resp_pc_q  <= RESET_PC;
            outst_q    <= '0;
            discard_q  <= '0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            resp_pc_q  <= resp_pc_d;
            outst_q    <= outst_d;
            discard_q  <= discard_d;
        end
    end

    upower_sync_fifo #(
        .WIDTH (ENT_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (clock),
        .rst_ni  (reset_n),
        .push_i  (fifo_push),
        .data_i  ({imem_resp_data, resp_pc_q}),
        .pop_i   (fifo_pop),
        .flush_i (redirect_valid),
        .data_o  (fifo_head),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

endmodule

// File: tb/tb_upower_fetch_unit.sv
// tb_upower_fetch_unit: randomized self-checking bench for upower_fetch_unit.
// The reference model treats the fetch unit as "a stream of consecutive
// PCs starting at the last redirect target", and the memory as an in-order
// queue of pending reads with a per-request latency.
module tb_upower_fetch_unit;

    localparam int unsigned DEPTH = 4;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b0;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid = 1'b0;
    logic [31:0] imem_resp_data = '0;
    logic        dec_valid;
    logic        dec_ready = 1'b0;
    logic [31:0] dec_instr;
    logic [31:0] dec_pc;

    always #5 clock = ~clock;

    upower_fetch_unit #(
        .ADDR_W     (32),
        .INSN_W     (32),
        .FIFO_DEPTH (DEPTH),
        .RESET_PC   (32'h0)
    ) dut (
        .clock           (clock),
        .reset_n         (reset_n),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_req_addr   (imem_req_addr),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
        .dec_valid       (dec_valid),
        .dec_ready       (dec_ready),
        .dec_instr       (dec_instr),
        .dec_pc          (dec_pc)
    );

    typedef struct {
        logic [31:0] addr;
        int unsigned due;
    } mem_req_t;

    mem_req_t    mem_q[$];
    int unsigned cyc = 0;
    int unsigned lat_cfg = 1;        // 0 selects a random latency per request
    logic [31:0] exp_req_addr = '0;
    logic [31:0] exp_dec_pc = '0;
    bit          prev_stall = 1'b0;
    logic [31:0] prev_addr = '0;
    int unsigned n_accepts = 0;
    int unsigned n_deliv = 0;
    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    function automatic logic [31:0] insn_of(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Entered at posedge+1; drives one cycle of inputs, checks at negedge.
    task automatic step(input bit rdy, input bit drdy, input bit redir, input logic [31:0] rpc);
        int unsigned lat;
        imem_req_ready = rdy;
        dec_ready      = drdy;
        redirect_valid = redir;
        redirect_pc    = rpc;
        if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
            imem_resp_valid = 1'b1;
            imem_resp_data  = insn_of(mem_q[0].addr);
            void'(mem_q.pop_front());
        end else begin
            imem_resp_valid = 1'b0;
            imem_resp_data  = $urandom;
        end

        @(negedge clock);
        if (prev_stall && !redir) begin
            check_eq("req_hold_valid", imem_req_valid, 1);
            check_eq("req_hold_addr", imem_req_addr, prev_addr);
        end
        if (redir) check_eq("req_in_redirect", imem_req_valid, 0);
        if (imem_req_valid) check_eq("req_addr", imem_req_addr, exp_req_addr);
        if (imem_req_valid && rdy && !redir) begin
            lat = (lat_cfg == 0) ? $urandom_range(1, 4) : lat_cfg;
            mem_q.push_back('{addr: imem_req_addr, due: cyc + lat});
            exp_req_addr++;
            n_accepts++;
        end
        prev_stall = imem_req_valid && !rdy && !redir;
        prev_addr  = imem_req_addr;
        check_eq("inflight_cap", (mem_q.size() <= DEPTH), 1);
        if (dec_valid && drdy && !redir) begin
            check_eq("dec_pc", dec_pc, exp_dec_pc);
            check_eq("dec_instr", dec_instr, insn_of(exp_dec_pc));
            exp_dec_pc++;
            n_deliv++;
        end
        if (redir) begin
            exp_dec_pc   = rpc;
            exp_req_addr = rpc;
        end

        @(posedge clock);
        #1;
        cyc++;
    endtask

    task automatic do_reset();
        #2;
        reset_n         = 1'b0;
        imem_resp_valid = 1'b0;
        redirect_valid  = 1'b0;
        imem_req_ready  = 1'b0;
        dec_ready       = 1'b0;
        #1;
        check_eq("rst_req_valid", imem_req_valid, 0);
        check_eq("rst_req_addr", imem_req_addr, 32'h0);
        check_eq("rst_dec_valid", dec_valid, 0);
        check_eq("rst_dec_pc", dec_pc, 32'h0);
        check_eq("rst_dec_instr", dec_instr, 32'h0);
        mem_q.delete();
        exp_req_addr = '0;
        exp_dec_pc   = '0;
        prev_stall   = 1'b0;
        repeat (2) @(posedge clock);
        #3;
        reset_n = 1'b1;
        #1;
        check_eq("idle_no_req", imem_req_valid, 0);
        @(posedge clock);
        #1;
        cyc++;
    endtask

    initial begin
        int unsigned base;
        bit          did_redirect;
        logic [31:0] rpc;

        // Streaming at latency 1: one instruction per cycle after a two-cycle fill.
        do_reset();
        lat_cfg = 1;
        base = n_deliv;
        repeat (40) step(1, 1, 0, '0);
        check_eq("stream_count", n_deliv - base, 38);

        // Request stall: address must hold and fetch resumes in sequence.
        repeat (5) step(0, 1, 0, '0);
        repeat (10) step(1, 1, 0, '0);

        // Reset in the middle of a stream.
        do_reset();
        repeat (10) step(1, 1, 0, '0);

        // Decode backpressure caps requests at the FIFO depth.
        do_reset();
        n_accepts = 0;
        repeat (15) step(1, 0, 0, '0);
        check_eq("bp_accepts", n_accepts, DEPTH);
        check_eq("bp_req_dropped", imem_req_valid, 0);
        base = n_deliv;
        repeat (12) step(1, 1, 0, '0);
        check_eq("bp_resume", (n_deliv - base >= DEPTH), 1);

        // Redirect with three requests in flight at latency 3.
        do_reset();
        lat_cfg = 3;
        did_redirect = 1'b0;
        for (int i = 0; i < 20 && !did_redirect; i++) begin
            if (mem_q.size() >= 3) begin
                step(1, 1, 1, 32'h40);
                did_redirect = 1'b1;
            end else begin
                step(1, 1, 0, '0);
            end
        end
        check_eq("redir_reached", did_redirect, 1);
        base = n_deliv;
        repeat (20) step(1, 1, 0, '0);
        check_eq("redir_delivered", (n_deliv - base >= 4), 1);

        // Address wrap through 0xFFFFFFFF.
        lat_cfg = 2;
        step(1, 1, 1, 32'hFFFF_FFFE);
        base = n_deliv;
        repeat (15) step(1, 1, 0, '0);
        check_eq("wrap_delivered", (n_deliv - base >= 3), 1);

        // Randomized traffic with random latency, stalls and redirects.
        lat_cfg = 0;
        base = n_deliv;
        for (int i = 0; i < 800; i++) begin
            rpc = ($urandom_range(0, 1) == 0) ? (32'hFFFF_FFFC + 32'($urandom_range(0, 3)))
                                              : $urandom;
            step($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
                 $urandom_range(0, 24) == 0, rpc);
        end
        check_eq("rand_progress", (n_deliv - base > 100), 1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
